// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic ops, iterative shift-add multiply
// and restoring divide, with a valid/ready request side and a held result side.
module alu_mc #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] aluA,
  input  logic [WIDTH-1:0] aluB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valE,
  output logic             cf,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             dz,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a request transfers on a posedge with in_valid && in_ready;
  // a result transfers on a posedge with out_valid && out_ready. Both sides
  // may transfer on the same edge (retire + accept back-to-back).

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, hi_q, lo_q, hi_d, lo_d;
  logic             is_div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] val_q;
  logic             cf_q, zf_q, sf_q, of_q, dz_q;

  logic             accept, start_iter, iter_last;
  logic [WIDTH-1:0] imm_val, rem_sub;
  logic             imm_cf, imm_of, imm_dz;
  logic [WIDTH:0]   add_w, sub_w, mul_sum, rem_shift;
  logic             div_ge;

  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign start_iter = (ifun == 4'b0011) || ((ifun == 4'b0100) && (aluA != '0));
  assign iter_last  = (cnt_q == CW'(WIDTH - 1));

  assign out_valid   = (state_q == DONE);
  assign valE        = val_q;
  assign cf          = cf_q;
  assign zf          = zf_q;
  assign sf          = sf_q;
  assign of          = of_q;
  assign dz          = dz_q;
  assign dbg_state_o = state_q;

  // Single-cycle results computed straight from the request inputs.
  always_comb begin
    add_w   = {1'b0, aluB} + {1'b0, aluA};
    sub_w   = {1'b0, aluB} - {1'b0, aluA};
    imm_val = aluA;
    imm_cf  = 1'b0;
    imm_of  = 1'b0;
    imm_dz  = 1'b0;
    case (ifun)
      4'b0001: begin
        imm_val = add_w[MSB:0];
        imm_cf  = add_w[WIDTH];
        imm_of  = (aluA[MSB] == aluB[MSB]) && (add_w[MSB] != aluA[MSB]);
      end
      4'b0010: begin
        imm_val = sub_w[MSB:0];
        imm_cf  = sub_w[WIDTH];
        imm_of  = (aluA[MSB] != aluB[MSB]) && (sub_w[MSB] != aluB[MSB]);
      end
      4'b0100: begin
        imm_val = '1;
        imm_dz  = 1'b1;
      end
      4'b0101: imm_val = aluB & aluA;
      4'b0110: imm_val = aluB | aluA;
      4'b0111: imm_val = aluB ^ aluA;
      default: imm_val = aluA;
    endcase
  end

  // One iteration step. {hi,lo} is the product pair for multiply and the
  // {remainder,dividend/quotient} pair for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    rem_shift = {hi_q, lo_q[MSB]};
    div_ge    = (rem_shift >= {1'b0, opa_q});
    rem_sub   = rem_shift[MSB:0] - opa_q;
    if (is_div_q) begin
      hi_d = div_ge ? rem_sub : rem_shift[MSB:0];
      lo_d = {lo_q[MSB-1:0], div_ge};
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[MSB:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = start_iter ? BUSY : DONE;
      BUSY: if (iter_last) state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) state_d = start_iter ? BUSY : DONE;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      val_q    <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Operands are latched here so later input changes cannot disturb an op.
        opa_q    <= aluA;
        is_div_q <= (ifun == 4'b0100);
        cnt_q    <= '0;
        hi_q     <= '0;
        lo_q     <= aluB;
        if (!start_iter) begin
          val_q <= imm_val;
          cf_q  <= imm_cf;
          of_q  <= imm_of;
          dz_q  <= imm_dz;
          zf_q  <= (imm_val == '0);
          sf_q  <= imm_val[MSB];
        end
      end else if (state_q == BUSY) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        cnt_q <= cnt_q + CW'(1);
        if (iter_last) begin
          val_q <= lo_d;
          cf_q  <= !is_div_q && (hi_d != '0);
          of_q  <= !is_div_q && (hi_d != '0);
          dz_q  <= 1'b0;
          zf_q  <= (lo_d == '0);
          sf_q  <= lo_d[MSB];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: an 8-bit instance under directed and random traffic checked
// against a wide-integer reference model, plus a 64-bit instance for long divides.
module tb_alu_mc;

  typedef struct packed {
    logic [63:0] val;
    logic        cf;
    logic        zf;
    logic        sf;
    logic        of;
    logic        dz;
    logic [7:0]  lat;
  } res_t;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- 8-bit instance ----------------
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] ifun;
  logic [7:0] aluA, aluB, valE;
  logic       cf, zf, sf, of, dz;
  logic [1:0] dbg8;

  alu_mc #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ifun(ifun), .aluA(aluA), .aluB(aluB), .out_valid(out_valid),
    .out_ready(out_ready), .valE(valE), .cf(cf), .zf(zf), .sf(sf), .of(of),
    .dz(dz), .dbg_state_o(dbg8)
  );

  // ---------------- 64-bit instance ----------------
  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [3:0]  ifun64;
  logic [63:0] aluA64, aluB64, valE64;
  logic        cf64, zf64, sf64, of64, dz64;
  logic [1:0]  dbg64;

  alu_mc #(.WIDTH(64)) u_dut64 (
    .clock(clock), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
    .ifun(ifun64), .aluA(aluA64), .aluB(aluB64), .out_valid(out_valid64),
    .out_ready(out_ready64), .valE(valE64), .cf(cf64), .zf(zf64), .sf(sf64),
    .of(of64), .dz(dz64), .dbg_state_o(dbg64)
  );

  // ---------------- reference model ----------------
  function automatic res_t model(input int w, input logic [3:0] f,
                                 input logic [63:0] a, input logic [63:0] b);
    res_t                 r;
    logic [127:0]         ua, ub, mask, full;
    logic signed [129:0]  sa, sb, s, lim;
    r     = '0;
    r.lat = 8'd1;
    mask  = (128'd1 << w) - 128'd1;
    ua    = 128'(a) & mask;
    ub    = 128'(b) & mask;
    lim   = 130'sd1 <<< (w - 1);
    sa    = $signed({2'b00, ua});
    sb    = $signed({2'b00, ub});
    if (sa >= lim) sa = sa - (lim <<< 1);
    if (sb >= lim) sb = sb - (lim <<< 1);
    full  = '0;
    case (f)
      4'd1: begin
        full = ub + ua;
        s    = sb + sa;
        r.cf = ((full >> w) != 0);
        r.of = (s >= lim) || (s < -lim);
      end
      4'd2: begin
        full = ub - ua;
        s    = sb - sa;
        r.cf = (ua > ub);
        r.of = (s >= lim) || (s < -lim);
      end
      4'd3: begin
        full  = ub * ua;
        r.cf  = ((full >> w) != 0);
        r.of  = r.cf;
        r.lat = 8'(w + 1);
      end
      4'd4: begin
        if (ua == 0) begin
          full = mask;
          r.dz = 1'b1;
        end else begin
          full  = ub / ua;
          r.lat = 8'(w + 1);
        end
      end
      4'd5:    full = ub & ua;
      4'd6:    full = ub | ua;
      4'd7:    full = ub ^ ua;
      default: full = ua;
    endcase
    full  = full & mask;
    r.val = full[63:0];
    r.zf  = (full == 0);
    r.sf  = full[w-1];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard / compare process (8-bit) ----------------
  res_t exp_q[$];
  res_t cur;
  int   cyc_left = 0;
  bit   started  = 0;
  bit   cleared  = 0;
  logic exp_valid, exp_ready;

  always @(negedge clock) begin
    exp_valid = (exp_q.size() > 0) && (cyc_left == 0);
    exp_ready = (exp_q.size() == 0) || (exp_valid && out_ready);
    if (started) begin
      tests++;
      if (out_valid !== exp_valid || in_ready !== exp_ready) begin
        fails++;
        $display("FAIL handshake @%0t: out_valid=%b in_ready=%b expected %b %b",
                 $time, out_valid, in_ready, exp_valid, exp_ready);
      end
      if (exp_valid || cleared) begin
        tests++;
        if ({valE, cf, zf, sf, of, dz} !== {cur.val[7:0], cur.cf, cur.zf, cur.sf, cur.of, cur.dz}) begin
          fails++;
          $display("FAIL result @%0t: valE=%0h cf%b zf%b sf%b of%b dz%b expected %0h cf%b zf%b sf%b of%b dz%b",
                   $time, valE, cf, zf, sf, of, dz, cur.val[7:0], cur.cf, cur.zf, cur.sf, cur.of, cur.dz);
        end
      end
    end
    if (reset) begin
      exp_q.delete();
      cur      = '0;
      cleared  = 1;
      started  = 1;
      cyc_left = 0;
    end else begin
      if (exp_valid && out_ready) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && cyc_left > 0) begin
        cyc_left--;
        if (cyc_left == 0) cur = exp_q[0];
      end
      if (in_valid && exp_ready) begin
        exp_q.push_back(model(8, ifun, 64'(aluA), 64'(aluB)));
        cyc_left = int'(exp_q[$].lat) - 1;
        cleared  = 0;
        if (cyc_left == 0) cur = exp_q[$];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op8(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                        output res_t r, output int lat, output int busy_ready);
    in_valid = 1'b1; ifun = f; aluA = a; aluB = b; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    ifun = 4'($urandom); aluA = 8'($urandom); aluB = 8'($urandom);
    lat = 0; busy_ready = 0;
    do begin
      @(negedge clock);
      lat++;
      if (!out_valid && in_ready) busy_ready++;
    end while (!out_valid && lat < 200);
    r = '0;
    r.val = 64'(valE); r.cf = cf; r.zf = zf; r.sf = sf; r.of = of; r.dz = dz;
    @(posedge clock); #1;
  endtask

  task automatic do_op64(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                         output res_t r, output int lat, output int busy_ready);
    in_valid64 = 1'b1; ifun64 = f; aluA64 = a; aluB64 = b; out_ready64 = 1'b1;
    @(posedge clock); #1;
    in_valid64 = 1'b0;
    aluA64 = {$urandom, $urandom}; aluB64 = {$urandom, $urandom};
    lat = 0; busy_ready = 0;
    do begin
      @(negedge clock);
      lat++;
      if (!out_valid64 && in_ready64) busy_ready++;
    end while (!out_valid64 && lat < 200);
    r = '0;
    r.val = valE64; r.cf = cf64; r.zf = zf64; r.sf = sf64; r.of = of64; r.dz = dz64;
    @(posedge clock); #1;
  endtask

  function automatic logic [7:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h7F;
      3:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    res_t m, r;
    int   lat, br, seen;

    reset = 1'b1;
    in_valid = 0; ifun = 0; aluA = 0; aluB = 0; out_ready = 1;
    in_valid64 = 0; ifun64 = 0; aluA64 = 0; aluB64 = 0; out_ready64 = 1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Hand-computed values that pin the reference model.
    m = model(8, 4'd1, 64'h01, 64'h7F);
    check("model add 7F+01", {m.val[7:0], m.of, m.sf, m.cf}, {8'h80, 3'b110});
    m = model(8, 4'd2, 64'h01, 64'h00);
    check("model sub 00-01", {m.val[7:0], m.cf, m.of}, {8'hFF, 2'b10});
    m = model(8, 4'd3, 64'h11, 64'h10);
    check("model mul 10*11", {m.val[7:0], m.cf, m.lat}, {8'h10, 1'b1, 8'd9});
    m = model(64, 4'd4, 64'd7, 64'd100);
    check("model div 100/7", {m.val, m.lat}, {64'd14, 8'd65});

    // Directed 8-bit cases.
    do_op8(4'd1, 8'h01, 8'h7F, r, lat, br);
    check("add ovf val/of/sf/cf/zf", {r.val[7:0], r.of, r.sf, r.cf, r.zf}, {8'h80, 4'b1100});
    check("add latency", 64'(lat), 64'd1);
    do_op8(4'd2, 8'h01, 8'h00, r, lat, br);
    check("sub borrow val/cf/sf/of", {r.val[7:0], r.cf, r.sf, r.of}, {8'hFF, 3'b110});
    do_op8(4'd1, 8'h01, 8'hFF, r, lat, br);
    check("add wrap val/cf/zf", {r.val[7:0], r.cf, r.zf}, {8'h00, 2'b11});
    do_op8(4'd3, 8'h11, 8'h10, r, lat, br);
    check("mul val/cf/of", {r.val[7:0], r.cf, r.of}, {8'h10, 2'b11});
    check("mul latency", 64'(lat), 64'd9);
    check("mul in_ready during busy", 64'(br), 64'd0);
    do_op8(4'd4, 8'd7, 8'd200, r, lat, br);
    check("div8 val/lat", {r.val[7:0], 8'(lat)}, {8'd28, 8'd9});

    // Stall in DONE with a competing request, then retire+accept on one edge.
    in_valid = 1; ifun = 4'd6; aluA = 8'h0F; aluB = 8'hA0; out_ready = 0;
    @(posedge clock); #1;
    ifun = 4'd1; aluA = 8'h01; aluB = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall out_valid/in_ready", {out_valid, in_ready}, 2'b10);
      check("stall valE", 64'(valE), 64'hAF);
      @(posedge clock); #1;
    end
    out_ready = 1; ifun = 4'd7; aluA = 8'hFF; aluB = 8'h0F;
    @(negedge clock);
    check("b2b in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    in_valid = 0;
    @(negedge clock);
    check("b2b new result", {out_valid, valE, sf}, {1'b1, 8'hF0, 1'b1});
    @(posedge clock); #1;

    // 64-bit long divide and divide-by-zero bypass.
    do_op64(4'd4, 64'd7, 64'd100, r, lat, br);
    check("div64 val", r.val, 64'd14);
    check("div64 latency", 64'(lat), 64'd65);
    check("div64 in_ready during busy", 64'(br), 64'd0);
    do_op64(4'd4, 64'd0, 64'd12345, r, lat, br);
    check("div64 by zero val/dz/cf/of", {r.val, r.dz, r.cf, r.of}, {64'hFFFF_FFFF_FFFF_FFFF, 3'b100});
    check("div64 by zero latency", 64'(lat), 64'd1);

    // Reset three cycles into a divide; a request during reset is ignored.
    in_valid64 = 1; ifun64 = 4'd4; aluA64 = 64'd3; aluB64 = 64'd1000;
    @(posedge clock); #1;
    in_valid64 = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1; in_valid64 = 1; ifun64 = 4'd1;
    @(posedge clock); #1;
    reset = 0; in_valid64 = 0;
    @(negedge clock);
    check("reset mid-div outputs", {out_valid64, valE64, cf64, zf64, sf64, of64, dz64}, '0);
    check("reset mid-div in_ready", 64'(in_ready64), 64'd1);
    seen = 0;
    repeat (70) begin
      @(negedge clock);
      if (out_valid64) seen++;
    end
    check("no stale result after reset", 64'(seen), 64'd0);
    @(posedge clock); #1;

    // Randomized traffic on the 8-bit instance, checked by the compare process.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      ifun      = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 7)) : 4'($urandom);
      aluA      = rand_opnd();
      aluB      = rand_opnd();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    reset = 0; in_valid = 0; out_ready = 1;
    repeat (20) @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, operand/result width in bits (legal 8..64, even).
REQ-002 SHALL provide port clock  input  1  single clock; all state updates on posedge clock.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 SHALL provide port in_valid  input  1  operation request valid.
REQ-005 SHALL provide port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL provide port ifun  input  4  operation code, captured on acceptance.
REQ-007 SHALL provide ports aluA, aluB  input  WIDTH each  operands, captured on acceptance.
REQ-008 SHALL provide port out_valid  output  1  result and flags valid.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-010 SHALL provide port valE  output  WIDTH  result.
REQ-011 SHALL provide ports cf, zf, sf, of, dz  output  1 each  carry/borrow, zero, sign, signed overflow, divide-by-zero.

Function
REQ-012 SHALL accept a request on a posedge where in_valid and in_ready are both 1; inputs at other times SHALL be ignored.
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; IDLE->DONE for 1-cycle ops, IDLE->BUSY for mul/div, BUSY->DONE after WIDTH iterations, DONE->IDLE on out_ready without new acceptance.
REQ-014 SHALL drive in_ready=1 in IDLE, and in DONE when out_ready=1 (back-to-back: result retired and new request accepted on same edge); 0 in BUSY.
REQ-015 SHALL drive out_valid=1 only in DONE; valE and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 ifun 0001 SHALL produce valE=(aluB+aluA) mod 2^WIDTH, cf=unsigned carry-out, of=1 when aluA,aluB signs equal and result sign differs; latency 1.
REQ-017 ifun 0010 SHALL produce valE=(aluB-aluA) mod 2^WIDTH, cf=1 when aluA>aluB unsigned, of=1 when aluB,aluA signs differ and result sign differs from aluB; latency 1.
REQ-018 ifun 0011 SHALL produce valE=low WIDTH bits of unsigned aluB*aluA via iterative shift-add, cf=of=1 when high WIDTH bits nonzero; out_valid WIDTH+1 cycles after acceptance.
REQ-019 ifun 0100 SHALL produce unsigned quotient aluB/aluA via iterative restoring division, cf=of=0; out_valid WIDTH+1 cycles after acceptance.
REQ-020 ifun 0100 with aluA=0 SHALL bypass iteration: valE=all ones, dz=1, cf=of=0, latency 1.
REQ-021 ifun 0101/0110/0111 SHALL produce aluB&aluA / aluB|aluA / aluB^aluA, cf=of=0, latency 1.
REQ-022 any other ifun SHALL produce valE=aluA, cf=of=0, latency 1.
REQ-023 zf SHALL equal (valE==0) and sf SHALL equal valE[WIDTH-1] for every op; dz SHALL be 0 except per REQ-020.
REQ-024 out_valid=1 with no out_ready SHALL stall indefinitely; no new request accepted.
REQ-025 operand changes on aluA/aluB/ifun during BUSY SHALL not affect the in-flight result.

Reset
REQ-026 reset=1 at a posedge SHALL force IDLE and clear valE, cf, zf, sf, of, dz, out_valid to 0 on that edge, including mid-BUSY (in-flight op discarded, no result emitted).
REQ-027 reset SHALL dominate acceptance: in_valid during reset cycle SHALL be ignored; in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-028 all internal iteration counters and partial registers SHALL be cleared by reset.

Verification
REQ-029 WIDTH=8, add aluB=0x7F aluA=0x01, out_ready=1 -> out_valid next cycle, valE=0x80, of=1, sf=1, cf=0, zf=0.
REQ-030 WIDTH=8, sub aluB=0x00 aluA=0x01 -> valE=0xFF, cf=1, sf=1, of=0; then add 0xFF+0x01 -> valE=0x00, cf=1, zf=1.
REQ-031 WIDTH=8, mul aluB=0x10 aluA=0x11 -> out_valid exactly 9 cycles after acceptance, valE=0x10, cf=of=1; in_ready=0 throughout BUSY.
REQ-032 WIDTH=64, div aluB=100 aluA=7 -> valE=14 after 65 cycles; div by aluA=0 -> valE=all ones, dz=1, latency 1.
REQ-033 out_ready held 0 for 5 cycles in DONE -> valE/flags stable, in_ready=0; then out_ready=1 with in_valid=1 -> retire and accept on same edge.
REQ-034 reset asserted 3 cycles into a div -> next cycle IDLE, out_valid=0, all outputs 0; no stale result after deassert.
